// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding memory bus arbiter, data port over fetch port
// Flushed fetches complete on the bus but their result is dropped.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    stallreq_if,
  output logic                    stallreq_mem,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb,
  input  logic                    bus_addr_ok,
  input  logic                    bus_data_ok,
  input  logic [DATA_WIDTH-1:0]   bus_rdata
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

  state_t                state_q, state_d;
  logic                  discard_q, discard_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [SW-1:0]         bus_wstrb_q, bus_wstrb_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      discard_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_rdata_q <= '0;
      data_valid_q <= 1'b0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      inst_valid_q <= inst_valid_d;
      inst_rdata_q <= inst_rdata_d;
      data_valid_q <= data_valid_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    inst_valid_d = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_valid_d = 1'b0;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        // A completion pulse blocks any issue that cycle, so requesters can drop or change their request.
        if (!(inst_valid_q || data_valid_q)) begin
          if (data_req) begin
            bus_req_d   = 1'b1;
            bus_we_d    = data_we;
            bus_addr_d  = data_addr;
            bus_wdata_d = data_wdata;
            bus_wstrb_d = data_wstrb;
            state_d     = D_ADDR;
          end else if (inst_req) begin
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = inst_addr;
            bus_wstrb_d = '0;
            state_d     = I_ADDR;
          end
        end
      end
      I_ADDR: begin
        if (flush) discard_d = 1'b1;
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          state_d   = I_DATA;
        end
      end
      I_DATA: begin
        if (flush) discard_d = 1'b1;
        if (bus_data_ok) begin
          inst_rdata_d = bus_rdata;
          inst_valid_d = !(discard_q || flush);
          discard_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      D_ADDR: begin
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          state_d   = D_DATA;
        end
      end
      D_DATA: begin
        if (bus_data_ok) begin
          if (!bus_we_q) data_rdata_d = bus_rdata;
          data_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_valid   = inst_valid_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_valid   = data_valid_q;
  assign data_rdata   = data_rdata_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_wstrb    = bus_wstrb_q;
  assign stallreq_if  = inst_req & ~inst_valid_q;
  assign stallreq_mem = data_req & ~data_valid_q;

endmodule
